// File: rtl/lcd_controller_pkg.sv
// +---------------------------------------------------------------------------+
// | lcd_controller_pkg: FSM states, MMIO offsets and status bits for the LCD  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package lcd_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4
    } lcd_state_t;

    localparam logic [1:0] c_REG_DATA   = 2'b00;
    localparam logic [1:0] c_REG_CMD    = 2'b01;
    localparam logic [1:0] c_REG_STATUS = 2'b10;
    localparam logic [1:0] c_REG_CLR    = 2'b11;

    localparam int c_STAT_BUSY    = 0;
    localparam int c_STAT_FULL    = 1;
    localparam int c_STAT_OVF     = 2;
    localparam int c_STAT_LVL_LSB = 8;
    localparam int c_STAT_LVL_MSB = 11;

    // Clear-display and return-home need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_controller_sync_fifo.sv
// +---------------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO with push/pop, full/empty and fill level     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [3:0]       level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign level     = 4'(r_count);
    assign rdata     = r_mem[r_rd_ptr];
    // Full is judged on the current count, so a push never rides on a same-cycle pop.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcd_controller.sv
// +---------------------------------------------------------------------------+
// | lcd_controller: MMIO-fed HD44780 bus sequencer (setup, E pulse, hold, exec)|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module lcd_controller
    import lcd_controller_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 8,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 80,
    parameter int T_EXEC_LONG = 3200,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_we,
    input  logic [1:0]  reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [31:0] reg_rdata,
    output logic [7:0]  lcd_data,
    output logic [1:0]  lcd_ctrl,
    output logic        lcd_enable,
    output logic        irq_idle
);

    lcd_state_t       r_state;
    lcd_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic             r_rs;
    logic             w_rs_nxt;
    logic             r_enable;
    logic             w_enable_nxt;
    logic             r_overflow;

    logic             w_push;
    logic             w_push_rs;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [8:0]       w_fifo_rdata;
    logic [3:0]       w_level;
    logic             w_timer_zero;
    logic [31:0]      w_status;

    assign w_push    = reg_we && ((reg_addr == c_REG_DATA) || (reg_addr == c_REG_CMD));
    assign w_push_rs = (reg_addr == c_REG_DATA);
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata ({w_push_rs, reg_wdata}),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (reg_we && (reg_addr == c_REG_CLR)) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_data   <= '0;
            r_rs     <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_data   <= w_data_nxt;
            r_rs     <= w_rs_nxt;
            r_enable <= w_enable_nxt;
        end
    end

    assign w_timer_zero = (r_timer == '0);

    // Every phase counts down to zero, then reloads for the next phase.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_data_nxt   = r_data;
        w_rs_nxt     = r_rs;
        w_enable_nxt = r_enable;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_data_nxt  = w_fifo_rdata[7:0];
                    w_rs_nxt    = w_fifo_rdata[8];
                    w_timer_nxt = CNT_W'(T_SETUP - 1);
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_timer_zero) begin
                    w_enable_nxt = 1'b1;
                    w_timer_nxt  = CNT_W'(T_PULSE - 1);
                    w_state_nxt  = ST_PULSE;
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (w_timer_zero) begin
                    w_enable_nxt = 1'b0;
                    w_timer_nxt  = CNT_W'(T_HOLD - 1);
                    w_state_nxt  = ST_HOLD;
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (w_timer_zero) begin
                    w_timer_nxt = is_long_cmd(r_rs, r_data) ? CNT_W'(T_EXEC_LONG - 1)
                                                            : CNT_W'(T_EXEC - 1);
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (w_timer_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_enable_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_status                                = '0;
        w_status[c_STAT_BUSY]                   = (r_state != ST_IDLE) || !w_empty;
        w_status[c_STAT_FULL]                   = w_full;
        w_status[c_STAT_OVF]                    = r_overflow;
        w_status[c_STAT_LVL_MSB:c_STAT_LVL_LSB] = w_level;
    end

    assign reg_rdata  = w_status;
    assign lcd_data   = r_data;
    assign lcd_ctrl   = {r_rs, 1'b0};
    assign lcd_enable = r_enable;
    assign irq_idle   = w_empty && (r_state == ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lcd_controller.sv
// +---------------------------------------------------------------------------+
// | tb_lcd_controller: timeline model of the LCD bus cycles plus directed tests |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_lcd_controller;

    localparam int TS    = 2;
    localparam int TP    = 4;
    localparam int TH    = 2;
    localparam int TE    = 10;
    localparam int TEL   = 40;
    localparam int DEPTH = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        reg_we    = 1'b0;
    logic [1:0]  reg_addr  = 2'b00;
    logic [7:0]  reg_wdata = 8'h00;
    logic [31:0] reg_rdata;
    logic [7:0]  lcd_data;
    logic [1:0]  lcd_ctrl;
    logic        lcd_enable;
    logic        irq_idle;

    always #5 clk = ~clk;

    lcd_controller #(
        .FIFO_DEPTH  (DEPTH),
        .T_SETUP     (TS),
        .T_PULSE     (TP),
        .T_HOLD      (TH),
        .T_EXEC      (TE),
        .T_EXEC_LONG (TEL),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .lcd_data   (lcd_data),
        .lcd_ctrl   (lcd_ctrl),
        .lcd_enable (lcd_enable),
        .irq_idle   (irq_idle)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a transaction popped in cycle P occupies cycles P+1 .. P+len,
    // with E high on cycles P+1+TS .. P+TS+TP.
    logic [8:0] mq[$];
    logic [7:0] m_data  = 8'h00;
    logic       m_rs    = 1'b0;
    logic       m_ovf   = 1'b0;
    int         m_pop   = -1000;
    int         m_len   = 0;
    bit         m_valid = 1'b0;

    int         rise_cyc[$];
    logic [7:0] rise_data[$];
    logic [1:0] rise_ctrl[$];
    int         fall_cyc[$];
    logic       prev_e = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_txn();
        return (cyc > m_pop) && (cyc <= m_pop + m_len);
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_data  = 8'h00;
            m_rs    = 1'b0;
            m_ovf   = 1'b0;
            m_pop   = -1000;
            m_len   = 0;
            m_valid = 1'b1;
        end else begin
            bit         was_full;
            logic [8:0] ent;
            was_full = (mq.size() == DEPTH);
            if (!m_txn() && mq.size() > 0) begin
                ent    = mq.pop_front();
                m_rs   = ent[8];
                m_data = ent[7:0];
                m_pop  = cyc;
                m_len  = TS + TP + TH +
                         ((!m_rs && m_data >= 8'h01 && m_data <= 8'h03) ? TEL : TE);
            end
            if (reg_we && reg_addr <= 2'd1) begin
                if (was_full) m_ovf = 1'b1;
                else          mq.push_back({reg_addr == 2'd0, reg_wdata});
            end
            if (reg_we && reg_addr == 2'd3) m_ovf = 1'b0;
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            bit          busy;
            bit          e_exp;
            logic [31:0] st;
            busy  = m_txn() || (mq.size() > 0);
            e_exp = (cyc >= m_pop + 1 + TS) && (cyc <= m_pop + TS + TP);
            st        = '0;
            st[11:8]  = 4'(mq.size());
            st[2]     = m_ovf;
            st[1]     = (mq.size() == DEPTH);
            st[0]     = busy;
            chk("lcd_data", 32'(lcd_data), 32'(m_data));
            chk("lcd_ctrl", 32'(lcd_ctrl), 32'({m_rs, 1'b0}));
            chk("lcd_enable", 32'(lcd_enable), 32'(e_exp));
            chk("reg_rdata", reg_rdata, st);
            chk("irq_idle", 32'(irq_idle), 32'(!busy));
            if (lcd_enable === 1'b1 && prev_e === 1'b0) begin
                rise_cyc.push_back(cyc);
                rise_data.push_back(lcd_data);
                rise_ctrl.push_back(lcd_ctrl);
            end
            if (lcd_enable === 1'b0 && prev_e === 1'b1) fall_cyc.push_back(cyc);
            prev_e = lcd_enable;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_we    = 1'b0;
        reg_addr  = 2'b00;
        reg_wdata = 8'h00;
    endtask

    task automatic wait_idle(input int max, output int at);
        int n = 0;
        while (irq_idle !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        at = cyc;
        if (irq_idle !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_idle timeout at cycle %0d: got busy expected idle", cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d: got running expected finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int at;
        int n0;
        int r;

        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_status", reg_rdata, 32'h0);
        chk("reset_e", 32'(lcd_enable), 32'd0);
        chk("reset_data", 32'(lcd_data), 32'd0);
        chk("reset_ctrl", 32'(lcd_ctrl), 32'd0);
        chk("reset_irq", 32'(irq_idle), 32'd1);
        rst_n = 1'b1;
        tick();

        // Reset while E is high.
        w = cyc;
        wr(2'b00, 8'h5A);
        repeat (4) tick();
        chk("midpulse_e_high", 32'(lcd_enable), 32'd1);
        chk("midpulse_data", 32'(lcd_data), 32'h5A);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midpulse_rst_e", 32'(lcd_enable), 32'd0);
        chk("midpulse_rst_data", 32'(lcd_data), 32'd0);
        chk("midpulse_rst_ctrl", 32'(lcd_ctrl), 32'd0);
        chk("midpulse_rst_status", reg_rdata, 32'h0);
        tick();

        // Single data byte timing.
        w = cyc;
        wr(2'b00, 8'h41);
        wait_idle(100, at);
        chk("t1_idle_cycle", at, w + 20);
        r = rise_cyc.size() - 1;
        chk("t1_rise_cycle", rise_cyc[r], w + 4);
        chk("t1_rise_data", 32'(rise_data[r]), 32'h41);
        chk("t1_rise_ctrl", 32'(rise_ctrl[r]), 32'd2);
        chk("t1_pulse_len", fall_cyc[fall_cyc.size() - 1] - rise_cyc[r], 32'd4);

        // Long command, normal command, data.
        n0 = rise_cyc.size();
        wr(2'b01, 8'h01);
        wr(2'b01, 8'h38);
        wr(2'b00, 8'h41);
        wait_idle(300, at);
        chk("t2_rise_count", rise_cyc.size(), n0 + 3);
        if (rise_cyc.size() == n0 + 3) begin
            chk("t2_long_gap", rise_cyc[n0 + 1] - rise_cyc[n0], 32'd49);
            chk("t2_short_gap", rise_cyc[n0 + 2] - rise_cyc[n0 + 1], 32'd19);
            chk("t2_cmd_ctrl", 32'(rise_ctrl[n0]), 32'd0);
            chk("t2_cmd2_data", 32'(rise_data[n0 + 1]), 32'h38);
            chk("t2_data_ctrl", 32'(rise_ctrl[n0 + 2]), 32'd2);
        end

        // Six back-to-back bytes: one popped, four queued, one dropped.
        n0 = rise_cyc.size();
        for (int i = 0; i < 6; i++) wr(2'b00, 8'h61 + 8'(i));
        chk("t3_burst_status", reg_rdata, 32'h407);
        wait_idle(400, at);
        chk("t3_rise_count", rise_cyc.size(), n0 + 5);
        if (rise_cyc.size() == n0 + 5) begin
            for (int i = 0; i < 5; i++) chk("t3_order", 32'(rise_data[n0 + i]), 32'h61 + i);
        end

        // Clear overflow; status writes are ignored.
        wr(2'b11, 8'h00);
        chk("t4_ovf_cleared", reg_rdata, 32'h0);
        n0 = rise_cyc.size();
        wr(2'b10, 8'h55);
        repeat (5) tick();
        chk("t4_status_write_ignored", rise_cyc.size(), n0);
        chk("t4_status_idle", reg_rdata, 32'h0);

        // Push while full in the same cycle as a pop is dropped.
        for (int i = 0; i < 5; i++) wr(2'b00, 8'h70 + 8'(i));
        repeat (15) tick();
        wr(2'b00, 8'h7F);
        chk("t4_full_pop_push", reg_rdata, 32'h305);
        wait_idle(400, at);
        chk("t4_rise_count", rise_cyc.size(), n0 + 5);
        if (rise_cyc.size() == n0 + 5) begin
            for (int i = 0; i < 5; i++) chk("t4_order", 32'(rise_data[n0 + i]), 32'h70 + i);
        end

        // Reset mid-EXEC with two entries queued.
        wr(2'b11, 8'h00);
        n0 = rise_cyc.size();
        wr(2'b00, 8'h81);
        wr(2'b00, 8'h82);
        wr(2'b00, 8'h83);
        repeat (9) tick();
        chk("t5_pre_rst_status", reg_rdata, 32'h201);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst_status", reg_rdata, 32'h0);
        chk("t5_rst_irq", 32'(irq_idle), 32'd1);
        repeat (60) tick();
        chk("t5_no_more_pulses", rise_cyc.size(), n0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
